// File: rtl/serial_byte_sender.sv
// Serial byte driver: accepts a parallel word and shifts it out LSB first on
// data_out, qualified by timed write_out strobes. Optional: SERIAL_BYTE_SENDER_COUNT_EN.
module serial_byte_sender #(
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 10,
  parameter int GAP_CYCLES   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [2:0]            state_dbg_out
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
  ,
  output logic [15:0]           sent_count_out
`endif
);

  // Producer handshake: a word transfers on a rising clock edge where
  // byte_valid_in && byte_ready_out; byte_ready_out is high only in IDLE.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    SETUP      = 3'd2,
    STROBE     = 3'd3,
    GAP        = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  ready_q, ready_d;
  logic                  data_q, data_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (byte_valid_in && ready_q) begin
          shift_d   = byte_in;
          bit_cnt_d = '0;
          state_d   = WAIT_READY;
        end
      end
      WAIT_READY: if (status_in) state_d = SETUP;
      SETUP:      if (tcnt_q == SETUP_LAST) state_d = STROBE;
      STROBE:     if (tcnt_q == HOLD_LAST) state_d = GAP;
      GAP: begin
        if (tcnt_q == GAP_LAST) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = SETUP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timing counter only runs inside the timed phases and restarts on every state entry.
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_READY || state_q == DONE)
      tcnt_d = '0;
    else
      tcnt_d = tcnt_q + TW'(1);

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == WAIT_READY) || (state_d == SETUP) ||
              (state_d == STROBE) || (state_d == GAP);
    write_d = (state_d == STROBE);
    done_d  = (state_d == DONE);

    data_d = data_q;
    if (state_d == SETUP && state_q != SETUP) data_d = shift_d[0];

`ifdef SERIAL_BYTE_SENDER_COUNT_EN
    cnt_d = (state_q == DONE) ? cnt_q + 16'd1 : cnt_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tcnt_q    <= '0;
      ready_q   <= 1'b1;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
      cnt_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tcnt_q    <= tcnt_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign byte_ready_out = ready_q;
  assign data_out       = data_q;
  assign write_out      = write_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign state_dbg_out  = state_q;
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
  assign sent_count_out = cnt_q;
`endif

endmodule

// File: tb/tb_serial_byte_sender.sv
// Self-checking bench for serial_byte_sender: a negedge monitor records strobes
// and the tasks compare them against a cycle-arithmetic model of each word.
module tb_serial_byte_sender;

  localparam int W = 8;
  localparam int S = 1;
  localparam int H = 10;
  localparam int G = 10;
  localparam int P = S + H + G;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] byte_in = '0;
  logic         byte_valid_in = 1'b0;
  logic         byte_ready_out;
  logic         status_in = 1'b1;
  logic         data_out;
  logic         write_out;
  logic         busy_out;
  logic         done_out;
  logic [2:0]   state_dbg;
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
  logic [15:0]  sent_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_byte_sender #(
    .DATA_WIDTH(W), .SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .clock(clk),
    .reset(reset),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out),
    .status_in(status_in),
    .data_out(data_out),
    .write_out(write_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .state_dbg_out(state_dbg)
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
    ,
    .sent_count_out(sent_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic obs_bit_q[$];
  int   rise_q[$];
  int   fall_q[$];
  int   done_q[$];
  int   busy_cnt = 0;
  int   data_glitch = 0;
  logic wr_prev = 1'b0;
  logic data_prev = 1'b0;

  always @(negedge clk) begin
    if (write_out === 1'b1 && wr_prev !== 1'b1) begin
      obs_bit_q.push_back(data_out);
      rise_q.push_back(cyc);
    end
    if (write_out !== 1'b1 && wr_prev === 1'b1) fall_q.push_back(cyc);
    if (write_out === 1'b1 && wr_prev === 1'b1 && data_out !== data_prev) data_glitch++;
    if (done_out === 1'b1) done_q.push_back(cyc);
    if (busy_out === 1'b1) busy_cnt++;
    wr_prev   = write_out;
    data_prev = data_out;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    obs_bit_q.delete();
    rise_q.delete();
    fall_q.delete();
    done_q.delete();
    busy_cnt    = 0;
    data_glitch = 0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Offers a word and returns the cycle stamp seen at the negedge right after
  // the accepting edge (that negedge lies in WAIT_READY).
  task automatic offer(input logic [W-1:0] b, input bit keep_valid, output int a);
    int n;
    n = 0;
    byte_in       = b;
    byte_valid_in = 1'b1;
    while (byte_ready_out !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (byte_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: byte_ready_out=%b after %0d cycles, required 1", byte_ready_out, n);
    end
    @(posedge clk);
    @(negedge clk);
    a = cyc;
    if (!keep_valid) begin
      byte_valid_in = 1'b0;
      byte_in       = W'($urandom);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset         = 1'b1;
    byte_valid_in = 1'b1;
    byte_in       = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({byte_ready_out, write_out, data_out, busy_out, done_out, state_dbg} !== 8'b1000_0000) begin
        miscompares++;
        $display("FAIL reset_outputs: ready,write,data,busy,done,state=%b,%b,%b,%b,%b,%0d required 1,0,0,0,0,0",
                 byte_ready_out, write_out, data_out, busy_out, done_out, state_dbg);
      end
    end
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
    vectors++;
    if (sent_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: sent_count=%0d required 0", sent_count);
    end
`endif
    byte_valid_in = 1'b0;
    reset         = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_out !== 1'b0 || byte_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_accept: busy=%b ready=%b required 0,1", busy_out, byte_ready_out);
    end
  endtask

  // One word: delay = cycles after acceptance before status_in rises (0 = already high);
  // drop = pull status_in low in the middle of bit 3.
  task automatic test_send(input string name, input logic [W-1:0] b, input int delay, input bit drop);
    int a, r, setup0, done_exp, rise_exp;
    @(negedge clk);
    clear_mon();
    status_in = (delay == 0);
    offer(b, 1'b0, a);
    r = a;
    if (delay > 0) begin
      repeat (delay - 1) @(negedge clk);
      status_in = 1'b1;
      r = cyc;
    end
    setup0   = r + 1;
    done_exp = setup0 + W * P;
    if (drop) begin
      wait_until(setup0 + 3 * P + S + 2);
      status_in = 1'b0;
      wait_until(setup0 + 5 * P);
      status_in = 1'b1;
    end
    wait_until(done_exp + 3);

    vectors++;
    if (obs_bit_q.size() != W || rise_q.size() != W || fall_q.size() != W) begin
      miscompares++;
      $display("FAIL %s strobe_count: rises=%0d falls=%0d required %0d", name, rise_q.size(), fall_q.size(), W);
    end else begin
      for (int i = 0; i < W; i++) begin
        rise_exp = setup0 + S + i * P;
        vectors++;
        if (obs_bit_q[i] !== b[i] || rise_q[i] != rise_exp || fall_q[i] != rise_exp + H) begin
          miscompares++;
          $display("FAIL %s bit%0d: data=%b rise=%0d fall=%0d required data=%b rise=%0d fall=%0d",
                   name, i, obs_bit_q[i], rise_q[i], fall_q[i], b[i], rise_exp, rise_exp + H);
        end
      end
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != done_exp) begin
      miscompares++;
      $display("FAIL %s done: pulses=%0d first=%0d required 1 pulse at %0d", name, done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, done_exp);
    end
    vectors++;
    if (busy_cnt != done_exp - a || data_glitch != 0) begin
      miscompares++;
      $display("FAIL %s busy_data: busy_cycles=%0d glitches=%0d required %0d and 0", name, busy_cnt, data_glitch, done_exp - a);
    end
    vectors++;
    if (byte_ready_out !== 1'b1 || busy_out !== 1'b0 || write_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: ready=%b busy=%b write=%b required 1,0,0", name, byte_ready_out, busy_out, write_out);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, d1, rise_exp;
    logic [2*W-1:0] pair;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    status_in = 1'b1;
    offer(8'h0F, 1'b1, a1);
    byte_in = 8'hF0;
    offer(8'hF0, 1'b0, a2);
    d1 = a1 + 1 + W * P;
    vectors++;
    if (a2 != d1 + 2) begin
      miscompares++;
      $display("FAIL b2b_accept: second accepted at %0d required %0d", a2, d1 + 2);
    end
    wait_until(a2 + 1 + W * P + 3);
    pair = {8'hF0, 8'h0F};
    vectors++;
    if (rise_q.size() != 2 * W || obs_bit_q.size() != 2 * W) begin
      miscompares++;
      $display("FAIL b2b_strobes: rises=%0d required %0d", rise_q.size(), 2 * W);
    end else begin
      for (int i = 0; i < 2 * W; i++) begin
        rise_exp = (i < W) ? a1 + 1 + S + i * P : a2 + 1 + S + (i - W) * P;
        vectors++;
        if (obs_bit_q[i] !== pair[i] || rise_q[i] != rise_exp) begin
          miscompares++;
          $display("FAIL b2b_bit%0d: data=%b rise=%0d required data=%b rise=%0d", i, obs_bit_q[i], rise_q[i], pair[i], rise_exp);
        end
      end
    end
    vectors++;
    if (done_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_done: pulses=%0d required 2", done_q.size());
    end
`ifdef SERIAL_BYTE_SENDER_COUNT_EN
    vectors++;
    if (sent_count !== 16'd2) begin
      miscompares++;
      $display("FAIL b2b_count: sent_count=%0d required 2", sent_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int a;
    @(negedge clk);
    clear_mon();
    status_in = 1'b1;
    offer(W'($urandom), 1'b0, a);
    wait_until(a + 1 + S + 4 * P + 2);
    vectors++;
    if (write_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_strobe: write_out=%b required 1 in bit 4 strobe", write_out);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({byte_ready_out, write_out, data_out, busy_out, done_out, state_dbg} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL mid_reset: ready,write,data,busy,done,state=%b,%b,%b,%b,%b,%0d required 1,0,0,0,0,0",
               byte_ready_out, write_out, data_out, busy_out, done_out, state_dbg);
    end
    reset = 1'b0;
    repeat (200) @(negedge clk);
    vectors++;
    if (done_q.size() != 0 || rise_q.size() != 5) begin
      miscompares++;
      $display("FAIL mid_abort: done pulses=%0d rises=%0d required 0 and 5", done_q.size(), rise_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_send("basic", 8'b1001_1001, 0, 1'b0);
    test_send("status_wait", W'($urandom), 50, 1'b0);
    test_send("status_drop", 8'hA5, 0, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_send("after_reset", W'($urandom), 0, 1'b0);
    for (int k = 0; k < 4; k++) test_send("random", W'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
